// File: rtl/gate_sweep_ctrl_pkg.sv
// rtl/gate_sweep_ctrl_pkg.sv - shared state encodings, vector count and gate truth tables
package gate_sweep_ctrl_pkg;

   typedef logic [2:0] state_t;

   // Sequencer state encodings (3-bit, fixed values kept for legacy compatibility)
   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_APPLY  = 3'd1;
   localparam state_t ST_SETTLE = 3'd2;
   localparam state_t ST_SAMPLE = 3'd3;
   localparam state_t ST_REPORT = 3'd4;

   // Number of input combinations swept for a 2-input gate
   localparam int unsigned NUM_VECTORS = 4;

   // Expected gate_y per vector, bit index = {a,b}
   localparam logic [3:0] TT_NAND2 = 4'b0111;
   localparam logic [3:0] TT_AND2  = 4'b1000;
   localparam logic [3:0] TT_OR2   = 4'b1110;
   localparam logic [3:0] TT_XOR2  = 4'b0110;

endpackage

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// rtl/gate_sweep_ctrl_settle_timer.sv - 8-bit loadable down-counter timing the gate settle window
module settle_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic [7:0] load_val_i,
   input  logic       dec_i,
   output logic [7:0] value_o,
   output logic       expire_o
);

   logic [7:0] value_q;
   logic [7:0] value_d;

   // Load has priority over decrement; the count never goes below zero
   always_comb begin
      value_d = value_q;
      if (load_i) begin
         value_d = load_val_i;
      end else if (dec_i && (value_q != 8'd0)) begin
         value_d = value_q - 8'd1;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= 8'd0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value_o  = value_q;
   // Expire marks the last settle cycle, so the caller leaves on this edge
   assign expire_o = (value_q == 8'd1);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - 2-input gate self-test sequencer; optional GATE_SWEEP_CONTINUOUS_EN
module gate_sweep_ctrl
   import gate_sweep_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter logic [3:0]  EXPECT        = TT_NAND2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask,
   output logic [3:0] result_vec,
`ifdef GATE_SWEEP_CONTINUOUS_EN
   output logic [7:0] sweep_cnt,
`endif
   output logic       gate_a,
   output logic       gate_b,
   input  logic       gate_y
);

   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
   localparam bit         SKIP_SETTLE = (SETTLE_CYCLES == 0);
   localparam logic [1:0] LAST_IDX    = 2'(NUM_VECTORS - 1);

   state_t     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [1:0] gate_ab_q, gate_ab_d;
   logic       pass_q, pass_d;
   logic [3:0] mask_q, mask_d;
   logic [3:0] result_q, result_d;

   logic       start_sweep;
   logic       timer_load;
   logic       timer_dec;
   logic [7:0] timer_value;
   logic       timer_expire;

   settle_timer u_settle_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (timer_load),
      .load_val_i (SETTLE_LOAD),
      .dec_i      (timer_dec),
      .value_o    (timer_value),
      .expire_o   (timer_expire)
   );

   // Next-state logic for the sweep sequencer and its captured results
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      gate_ab_d   = gate_ab_q;
      pass_d      = pass_q;
      mask_d      = mask_q;
      result_d    = result_q;
      start_sweep = 1'b0;
      timer_load  = 1'b0;
      timer_dec   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            start_sweep = start;
         end
         ST_APPLY: begin
            timer_load = 1'b1;
            state_d    = SKIP_SETTLE ? ST_SAMPLE : ST_SETTLE;
         end
         ST_SETTLE: begin
            // A zero count can only arise from a corrupted timer; leave rather than stall
            if (timer_expire || (timer_value == 8'd0)) begin
               state_d = ST_SAMPLE;
            end else begin
               timer_dec = 1'b1;
            end
         end
         ST_SAMPLE: begin
            result_d[idx_q] = gate_y;
            mask_d[idx_q]   = gate_y ^ EXPECT[idx_q];
            if (idx_q == LAST_IDX) begin
               state_d = ST_REPORT;
               // Verdict must include the vector captured on this same edge
               pass_d  = (mask_d == 4'd0);
            end else begin
               idx_d     = idx_q + 2'd1;
               gate_ab_d = idx_q + 2'd1;
               state_d   = ST_APPLY;
            end
         end
         ST_REPORT: begin
            state_d = ST_IDLE;
`ifdef GATE_SWEEP_CONTINUOUS_EN
            start_sweep = start;
`endif
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (start_sweep) begin
         state_d   = ST_APPLY;
         idx_d     = 2'd0;
         gate_ab_d = 2'd0;
         pass_d    = 1'b0;
         mask_d    = 4'd0;
         result_d  = 4'd0;
      end
   end

   // Sequencer state and result registers; reset aborts a sweep without a done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         idx_q     <= 2'd0;
         gate_ab_q <= 2'd0;
         pass_q    <= 1'b0;
         mask_q    <= 4'd0;
         result_q  <= 4'd0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         gate_ab_q <= gate_ab_d;
         pass_q    <= pass_d;
         mask_q    <= mask_d;
         result_q  <= result_d;
      end
   end

`ifdef GATE_SWEEP_CONTINUOUS_EN
   logic [7:0] sweep_cnt_q, sweep_cnt_d;

   // Completed-sweep counter, saturating; only reset clears it
   always_comb begin
      sweep_cnt_d = sweep_cnt_q;
      if ((state_q == ST_SAMPLE) && (state_d == ST_REPORT) && (sweep_cnt_q != 8'hFF)) begin
         sweep_cnt_d = sweep_cnt_q + 8'd1;
      end
   end

   // Sweep counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sweep_cnt_q <= 8'd0;
      end else begin
         sweep_cnt_q <= sweep_cnt_d;
      end
   end

   assign sweep_cnt = sweep_cnt_q;
`endif

   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_REPORT);
   assign pass       = pass_q;
   assign fail_mask  = mask_q;
   assign result_vec = result_q;
   assign gate_a     = gate_ab_q[1];
   assign gate_b     = gate_ab_q[0];

endmodule
